// File: rtl/riscv_multicycle_controller.sv
// Multi-cycle RV32I control unit: decodes op/funct3/funct7 from IR and
// sequences the shared-memory, shared-ALU datapath one state per cycle.
module riscv_multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR1    = 4'd11;
  localparam logic [3:0] S_JALR2    = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_ILLEGAL  = 4'd14;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  logic [3:0] state_q, state_d;

  // Instruction-field decode shared by next-state and output logic
  logic [2:0] imm_dec;
  logic       r_legal, i_legal, br_legal, br_taken;
  logic [2:0] r_alu, i_alu, br_alu;

  // Internal, ungated versions of the write enables
  logic       pc_update, branch, adr_s, memwrite_s, irwrite_s, regwrite_s, done_s, ill_s;
  logic [1:0] result_s, srca_s, srcb_s;
  logic [2:0] alu_s, imm_s;

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RESET_STATE;
    else      state_q <= state_d;
  end

  // Decode immediate format, ALU operation and legality from IR fields
  always_comb begin
    imm_dec = IMM_I;
    case (op)
      OP_SW:   imm_dec = IMM_S;
      OP_B:    imm_dec = IMM_B;
      OP_JAL:  imm_dec = IMM_J;
      OP_LUI:  imm_dec = IMM_U;
      default: imm_dec = IMM_I;
    endcase

    r_legal = 1'b1;
    r_alu   = ALU_ADD;
    case (funct3)
      3'b000: begin
        if (funct7 == 7'b0000000)      r_alu = ALU_ADD;
        else if (funct7 == 7'b0100000) r_alu = ALU_SUB;
        else                           r_legal = 1'b0;
      end
      3'b111:  r_alu = ALU_AND;
      3'b110:  r_alu = ALU_OR;
      3'b010:  r_alu = ALU_SLT;
      default: r_legal = 1'b0;
    endcase

    i_legal = 1'b1;
    i_alu   = ALU_ADD;
    case (funct3)
      3'b000:  i_alu = ALU_ADD;
      3'b111:  i_alu = ALU_AND;
      3'b110:  i_alu = ALU_OR;
      3'b010:  i_alu = ALU_SLT;
      default: i_legal = 1'b0;
    endcase

    // slt yields 1 (nonzero) when rs1<rs2, so blt takes on ~Zero
    br_legal = 1'b1;
    br_alu   = ALU_SUB;
    br_taken = Zero;
    case (funct3)
      3'b000: begin br_alu = ALU_SUB; br_taken = Zero;  end
      3'b001: begin br_alu = ALU_SUB; br_taken = ~Zero; end
      3'b100: begin br_alu = ALU_SLT; br_taken = ~Zero; end
      3'b101: begin br_alu = ALU_SLT; br_taken = Zero;  end
      default: br_legal = 1'b0;
    endcase
  end

  // Next-state selection
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_B:         state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALR1;
          OP_LUI:       state_d = S_LUI;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_SW)      state_d = S_MEMWRITE;
        else if (op == OP_LW) state_d = S_MEMREAD;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = r_legal ? S_ALUWB : S_ILLEGAL;
      S_EXECI:    state_d = i_legal ? S_ALUWB : S_ILLEGAL;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = br_legal ? S_FETCH : S_ILLEGAL;
      S_JAL:      state_d = S_ALUWB;
      S_JALR1:    state_d = (funct3 == 3'b000) ? S_JALR2 : S_ILLEGAL;
      S_JALR2:    state_d = S_FETCH;
      S_LUI:      state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state mux selects and (ungated) enables
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_s      = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    done_s     = 1'b0;
    ill_s      = 1'b0;
    result_s   = 2'b00;
    srca_s     = 2'b00;
    srcb_s     = 2'b00;
    alu_s      = ALU_ADD;
    imm_s      = imm_dec;
    case (state_q)
      S_FETCH: begin
        irwrite_s = 1'b1;
        srcb_s    = 2'b10;
        result_s  = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        srca_s = 2'b01;
        srcb_s = 2'b01;
      end
      S_MEMADR: begin
        srca_s = 2'b10;
        srcb_s = 2'b01;
      end
      S_MEMREAD: adr_s = 1'b1;
      S_MEMWB: begin
        result_s   = 2'b01;
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_s      = 1'b1;
        memwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      S_EXECR: begin
        srca_s = 2'b10;
        srcb_s = 2'b00;
        alu_s  = r_alu;
      end
      S_EXECI: begin
        srca_s = 2'b10;
        srcb_s = 2'b01;
        alu_s  = i_alu;
      end
      S_ALUWB: begin
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      // An unsupported branch funct3 must not redirect the PC
      S_BRANCH: begin
        srca_s = 2'b10;
        srcb_s = 2'b00;
        if (br_legal) begin
          alu_s  = br_alu;
          branch = 1'b1;
          done_s = 1'b1;
        end
      end
      S_JAL: begin
        srca_s    = 2'b01;
        srcb_s    = 2'b10;
        pc_update = 1'b1;
      end
      S_JALR1: begin
        srca_s    = 2'b10;
        srcb_s    = 2'b01;
        imm_s     = IMM_I;
        result_s  = 2'b10;
        pc_update = (funct3 == 3'b000);
      end
      S_JALR2: begin
        srca_s     = 2'b01;
        srcb_s     = 2'b10;
        result_s   = 2'b10;
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      S_LUI: begin
        imm_s      = IMM_U;
        result_s   = 2'b11;
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      S_ILLEGAL: ill_s = 1'b1;
      default: ;
    endcase
  end

  // Enables are masked by rst so an asserted reset kills this cycle's writes at once
  assign PCWrite    = rst & (pc_update | (branch & br_taken));
  assign MemWrite   = rst & memwrite_s;
  assign IRWrite    = rst & irwrite_s;
  assign RegWrite   = rst & regwrite_s;
  assign instr_done = rst & done_s;
  assign illegal    = ill_s;
  assign AdrSrc     = adr_s;
  assign ResultSrc  = result_s;
  assign ALUSrcA    = srca_s;
  assign ALUSrcB    = srcb_s;
  assign ALUControl = alu_s;
  assign ImmSrc     = imm_s;

endmodule
